// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, branch flush and E-stage operand forwarding.
// Tracks its own shadow copy of the E/M/W register fields so no later-stage taps are needed.
module hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdD_i,
    input  logic                      useRs1D_i,
    input  logic                      useRs2D_i,
    input  logic                      regWriteD_i,
    input  logic                      resultSrcD_i,
    input  logic                      pcSrcE_i,
    output logic                      stallF_o,
    output logic                      stallD_o,
    output logic                      flushD_o,
    output logic                      flushE_o,
    output logic [1:0]                forwardAE_o,
    output logic [1:0]                forwardBE_o,
    output logic [CNT_WIDTH-1:0]      stallCount_o,
    output logic [CNT_WIDTH-1:0]      flushCount_o
);

    localparam logic [REG_ADDR_WIDTH-1:0] X0 = '0;

    logic [REG_ADDR_WIDTH-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic                      reg_write_e, load_e, reg_write_m, reg_write_w;
    logic                      rs1_hit, rs2_hit, lw_stall, flush_e;
    logic [1:0]                fwd_a, fwd_b;
    logic [CNT_WIDTH-1:0]      stall_count, flush_count;

    assign rs1_hit  = useRs1D_i && (rs1D_i == rd_e);
    assign rs2_hit  = useRs2D_i && (rs2D_i == rd_e);
    // A taken branch makes the decode instruction wrong-path, so it never needs to wait.
    assign lw_stall = load_e && reg_write_e && (rd_e != X0) && (rs1_hit || rs2_hit) && !pcSrcE_i;
    assign flush_e  = lw_stall || pcSrcE_i;

    always_comb begin
        fwd_a = 2'b00;
        if (reg_write_m && (rd_m != X0) && (rd_m == rs1_e))
            fwd_a = 2'b10;
        else if (reg_write_w && (rd_w != X0) && (rd_w == rs1_e))
            fwd_a = 2'b01;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (reg_write_m && (rd_m != X0) && (rd_m == rs2_e))
            fwd_b = 2'b10;
        else if (reg_write_w && (rd_w != X0) && (rd_w == rs2_e))
            fwd_b = 2'b01;
    end

    // Control outputs are held quiet for the whole reset cycle regardless of inputs.
    assign stallF_o     = !rst && lw_stall;
    assign stallD_o     = !rst && lw_stall;
    assign flushD_o     = !rst && pcSrcE_i;
    assign flushE_o     = !rst && flush_e;
    assign forwardAE_o  = rst ? 2'b00 : fwd_a;
    assign forwardBE_o  = rst ? 2'b00 : fwd_b;
    assign stallCount_o = stall_count;
    assign flushCount_o = flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_e       <= '0;
            rs2_e       <= '0;
            rd_e        <= '0;
            reg_write_e <= 1'b0;
            load_e      <= 1'b0;
            rd_m        <= '0;
            reg_write_m <= 1'b0;
            rd_w        <= '0;
            reg_write_w <= 1'b0;
        end else begin
            if (flush_e) begin
                rs1_e       <= '0;
                rs2_e       <= '0;
                rd_e        <= '0;
                reg_write_e <= 1'b0;
                load_e      <= 1'b0;
            end else begin
                // Unused sources are zeroed so they can never match a producer later.
                rs1_e       <= useRs1D_i ? rs1D_i : X0;
                rs2_e       <= useRs2D_i ? rs2D_i : X0;
                rd_e        <= rdD_i;
                reg_write_e <= regWriteD_i;
                load_e      <= resultSrcD_i;
            end
            rd_m        <= rd_e;
            reg_write_m <= reg_write_e;
            rd_w        <= rd_m;
            reg_write_w <= reg_write_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (lw_stall && (stall_count != '1))
                stall_count <= stall_count + CNT_WIDTH'(1);
            if (pcSrcE_i && (flush_count != '1))
                flush_count <= flush_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit; a second instance with 2-bit counters
// shares the stimulus and is used for saturation checks.
module tb_hazard_unit;

    logic       clk;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, rw, ld, pc;

    logic        stall_f, stall_d, flush_d, flush_e;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall_f, s_stall_d, s_flush_d, s_flush_e;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_unit #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .rs1D_i(rs1), .rs2D_i(rs2), .rdD_i(rd),
        .useRs1D_i(use1), .useRs2D_i(use2), .regWriteD_i(rw), .resultSrcD_i(ld),
        .pcSrcE_i(pc),
        .stallF_o(stall_f), .stallD_o(stall_d), .flushD_o(flush_d), .flushE_o(flush_e),
        .forwardAE_o(fwd_a), .forwardBE_o(fwd_b),
        .stallCount_o(stall_cnt), .flushCount_o(flush_cnt)
    );

    hazard_unit #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst),
        .rs1D_i(rs1), .rs2D_i(rs2), .rdD_i(rd),
        .useRs1D_i(use1), .useRs2D_i(use2), .regWriteD_i(rw), .resultSrcD_i(ld),
        .pcSrcE_i(pc),
        .stallF_o(s_stall_f), .stallD_o(s_stall_d), .flushD_o(s_flush_d), .flushE_o(s_flush_e),
        .forwardAE_o(s_fwd_a), .forwardBE_o(s_fwd_b),
        .stallCount_o(s_stall_cnt), .flushCount_o(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One decode slot: inputs change on the falling edge, outputs are read 1 ns later.
    task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] d, input logic u1, input logic u2,
                         input logic w, input logic l, input logic p);
        @(negedge clk);
        rst = r; rs1 = a1; rs2 = a2; rd = d;
        use1 = u1; use2 = u2; rw = w; ld = l; pc = p;
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        // Reset held with a taken branch on the input: flushes must stay low.
        drive(1, 1, 2, 3, 1, 1, 1, 1, 1);
        checks++; if (flush_d !== 1'b0) begin errors++; $display("FAIL reset_flushD got %b exp 0", flush_d); end
        checks++; if (flush_e !== 1'b0) begin errors++; $display("FAIL reset_flushE got %b exp 0", flush_e); end
        checks++; if (stall_f !== 1'b0 || stall_d !== 1'b0) begin errors++; $display("FAIL reset_stall got %b%b exp 00", stall_f, stall_d); end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
        checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd got %b/%b exp 00/00", fwd_a, fwd_b); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_alu_forward();
        nops(3);
        drive(0, 1, 2, 5, 1, 1, 1, 0, 0);
        drive(0, 5, 0, 6, 1, 0, 1, 0, 0);
        checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL alu_stall got %b exp 0", stall_f); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL alu_fwdA got %b exp 10", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL alu_fwdB got %b exp 00", fwd_b); end
    endtask

    task automatic test_distance2();
        nops(3);
        drive(0, 1, 2, 5, 1, 1, 1, 0, 0);
        drive(0, 1, 2, 8, 1, 1, 1, 0, 0);
        drive(0, 1, 5, 9, 1, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_b !== 2'b01) begin errors++; $display("FAIL dist2_fwdB got %b exp 01", fwd_b); end
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL dist2_fwdA got %b exp 00", fwd_a); end
    endtask

    task automatic test_load_use();
        nops(2);
        do_reset();
        drive(0, 2, 0, 7, 1, 0, 1, 1, 0);
        checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL lu_pre_stall got %b exp 0", stall_f); end
        drive(0, 7, 0, 9, 1, 0, 1, 0, 0);
        checks++; if ({stall_f, stall_d, flush_e, flush_d} !== 4'b1110) begin errors++; $display("FAIL lu_stall got %b exp 1110", {stall_f, stall_d, flush_e, flush_d}); end
        // F/D held: the consumer is presented again.
        drive(0, 7, 0, 9, 1, 0, 1, 0, 0);
        checks++; if ({stall_f, flush_e} !== 2'b00) begin errors++; $display("FAIL lu_release got %b exp 00", {stall_f, flush_e}); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL lu_fwdA got %b exp 01", fwd_a); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stallcnt got %0d exp 1", stall_cnt); end
        checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL lu_flushcnt got %0d exp 0", flush_cnt); end
    endtask

    task automatic test_mw_priority();
        nops(3);
        drive(0, 1, 0, 3, 1, 0, 1, 0, 0);
        drive(0, 2, 0, 3, 1, 0, 1, 0, 0);
        drive(0, 3, 3, 4, 1, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL mw_fwdA got %b exp 10", fwd_a); end
        checks++; if (fwd_b !== 2'b10) begin errors++; $display("FAIL mw_fwdB got %b exp 10", fwd_b); end
    endtask

    task automatic test_x0_unused();
        nops(3);
        drive(0, 1, 0, 0, 1, 0, 1, 1, 0);
        drive(0, 0, 0, 6, 1, 1, 1, 0, 0);
        checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL x0_stall got %b exp 0", stall_f); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL x0_fwd got %b/%b exp 00/00", fwd_a, fwd_b); end
        nops(2);
        drive(0, 1, 0, 4, 1, 0, 1, 1, 0);
        drive(0, 4, 4, 6, 0, 0, 1, 0, 0);
        checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL unused_stall got %b exp 0", stall_f); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin errors++; $display("FAIL unused_fwd got %b/%b exp 00/00", fwd_a, fwd_b); end
    endtask

    task automatic test_branch_load_use();
        nops(2);
        do_reset();
        drive(0, 2, 0, 7, 1, 0, 1, 1, 0);
        drive(0, 7, 0, 9, 1, 0, 1, 0, 1);
        checks++; if ({stall_f, stall_d} !== 2'b00) begin errors++; $display("FAIL br_stall got %b exp 00", {stall_f, stall_d}); end
        checks++; if ({flush_d, flush_e} !== 2'b11) begin errors++; $display("FAIL br_flush got %b exp 11", {flush_d, flush_e}); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL br_flushcnt got %0d exp 1", flush_cnt); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL br_stallcnt got %0d exp 0", stall_cnt); end
        checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL br_fwdA got %b exp 00", fwd_a); end
    endtask

    task automatic test_saturation();
        nops(2);
        do_reset();
        // A self-dependent load alternates stall / bubble: 10 slots give 5 stall cycles.
        for (int i = 0; i < 10; i++) drive(0, 7, 0, 7, 1, 0, 1, 1, 0);
        checks++; if (s_stall_f !== 1'b1) begin errors++; $display("FAIL sat_stall_last got %b exp 1", s_stall_f); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (s_stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got %0d exp 3", s_stall_cnt); end
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL sat_cnt16 got %0d exp 5", stall_cnt); end
        // Re-arm a stall, then assert reset in the stalling cycle.
        drive(0, 7, 0, 7, 1, 0, 1, 1, 0);
        drive(1, 7, 0, 7, 1, 0, 1, 1, 0);
        checks++; if ({s_stall_f, s_stall_d, s_flush_e, s_flush_d} !== 4'b0000) begin errors++; $display("FAIL sat_rst_ctl got %b exp 0000", {s_stall_f, s_stall_d, s_flush_e, s_flush_d}); end
        drive(0, 7, 0, 7, 1, 0, 1, 1, 0);
        checks++; if (s_stall_cnt !== 2'd0 || s_flush_cnt !== 2'd0) begin errors++; $display("FAIL sat_rst_cnt got %0d/%0d exp 0/0", s_stall_cnt, s_flush_cnt); end
        checks++; if ({s_stall_f, s_fwd_a, s_fwd_b} !== 5'b0) begin errors++; $display("FAIL sat_after_rst got %b exp 00000", {s_stall_f, s_fwd_a, s_fwd_b}); end
    endtask

    task automatic test_reset_mid_forward();
        nops(3);
        drive(0, 1, 2, 5, 1, 1, 1, 0, 0);
        drive(0, 5, 5, 6, 1, 1, 1, 0, 0);
        // Consumer in E, producer in M: forward would be 10 without reset.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL rstmid_fwd got %b exp 0000", {fwd_a, fwd_b}); end
        checks++; if ({flush_d, flush_e} !== 2'b00) begin errors++; $display("FAIL rstmid_flush got %b exp 00", {flush_d, flush_e}); end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if ({stall_f, fwd_a, fwd_b} !== 5'b0) begin errors++; $display("FAIL rstmid_after got %b exp 00000", {stall_f, fwd_a, fwd_b}); end
    endtask

    initial begin
        rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0;
        use1 = 1'b0; use2 = 1'b0; rw = 1'b0; ld = 1'b0; pc = 1'b0;
        test_reset();
        test_alu_forward();
        test_distance2();
        test_load_use();
        test_mw_priority();
        test_x0_unused();
        test_branch_load_use();
        test_saturation();
        test_reset_mid_forward();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Feedback-direction companion to the decode→execute pipeline register: observes decode-stage register usage and the execute-stage branch decision, and drives stall, flush and forwarding controls back upstream.
- Keeps its own shadow of the E, M and W stage destination/source fields, so it needs no taps from the later pipeline registers.
- Sits beside the five-stage pipeline. Its outputs drive fetch PC enable, the F/D register enable/clear, the D/E register clear and the E-stage operand muxes.

Parameters:
- REG_ADDR_WIDTH, 5, width of register addresses.
- CNT_WIDTH, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rs1D_i  in  REG_ADDR_WIDTH  decode source register 1.
- rs2D_i  in  REG_ADDR_WIDTH  decode source register 2.
- rdD_i  in  REG_ADDR_WIDTH  decode destination register.
- useRs1D_i  in  1  decode instruction reads rs1.
- useRs2D_i  in  1  decode instruction reads rs2.
- regWriteD_i  in  1  decode instruction writes rd.
- resultSrcD_i  in  1  1 = decode instruction is a load.
- pcSrcE_i  in  1  branch/jump taken, resolved in E.
- stallF_o  out  1  hold PC.
- stallD_o  out  1  hold F/D register.
- flushD_o  out  1  clear F/D register.
- flushE_o  out  1  clear D/E register.
- forwardAE_o  out  2  E operand A select: 00 register file, 10 M ALU result, 01 W result.
- forwardBE_o  out  2  E operand B select, same encoding.
- stallCount_o  out  CNT_WIDTH  cycles stalled.
- flushCount_o  out  CNT_WIDTH  taken-branch flushes.

Behaviour:
- Shadow state:
  - E stage: rs1E, rs2E, rdE, regWriteE, loadE.
  - M stage: rdM, regWriteM.
  - W stage: rdW, regWriteW.
  - A bubble is all fields zero.
- Reset:
  - All shadow stages become bubbles; both counters become 0.
  - While rst=1, every stall, flush and forward output is forced to 0, independent of inputs.
- lwStall (combinational):
  - Condition: loadE & regWriteE & rdE≠0 & ((useRs1D_i & rs1D_i==rdE) | (useRs2D_i & rs2D_i==rdE)) & ~pcSrcE_i.
  - Taken branch suppresses the stall because the D instruction is wrong-path.
- Stall/flush outputs (combinational):
  - stallF_o = stallD_o = lwStall.
  - flushD_o = pcSrcE_i.
  - flushE_o = lwStall | pcSrcE_i.
- Forwarding, A side (combinational):
  - forwardAE_o=10 if regWriteM & rdM≠0 & rdM==rs1E.
  - Otherwise 01 if regWriteW & rdW≠0 & rdW==rs1E.
  - Otherwise 00. M has priority over W.
- Forwarding, B side: identical rule using rs2E.
- x0 never forwards and never causes a stall.
- Shadow advance on each clock edge with rst=0:
  - E ← bubble if flushE_o, else D inputs. rs fields are captured as 0 when the matching use flag is 0.
  - M ← E (rd and regWrite); W ← M.
- Latency:
  - A load in E stalls its consumer exactly one cycle.
  - After the bubble, the load sits in W and the consumer in E, which selects forward=01.
- Counters:
  - stallCount increments on each cycle with lwStall=1.
  - flushCount increments on each cycle with pcSrcE_i=1.
  - Both saturate at all-ones (no wrap) and are cleared only by rst.
- Simultaneous lwStall condition and pcSrcE_i: no stall, flushD and flushE asserted, stallCount unchanged.
- Reset asserted mid-stall: the next cycle shows no stall and all forwards are 00.

Test Plan:
- ALU dependency: add x5 (regWriteD=1, rd=5), then add using rs1=5 one cycle later → when consumer in E, forwardAE_o=10; stall=0.
- Distance-2 dependency: insert one independent instruction between producer x5 and consumer rs2=5 → forwardBE_o=01.
- Load-use: load x7 then consumer rs1=7 →
  - Cycle with load in E: stallF/stallD/flushE=1.
  - Next cycle: no stall, forwardAE_o=01.
  - stallCount_o=1.
- Same register in M and W: write x3 twice back-to-back, consumer reads x3 → forwardAE_o=10 (M priority).
- x0 and unused operands: producer rd=0 or useRs1D_i=0 with matching address → no stall, forward=00.
- Branch over load-use: pcSrcE_i=1 while lwStall condition holds → stall=0, flushD=flushE=1, flushCount_o +1, stallCount_o unchanged.
- Reset and saturation (CNT_WIDTH=2): hold stall condition 5 cycles → stallCount_o stays 3. Then rst=1 for one cycle → counters 0 and all outputs 0.
